// File: rtl/sr_prog_pkg.sv
// Shared types and constants for the configuration shift-register programming controller.
package sr_prog_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_SHIFT,
    ST_LATCH
  } state_e;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DATA   = 4'h8;
  localparam logic [3:0] OFF_RDATA  = 4'hC;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_WORD_REQ = 2;
  localparam int STAT_ERR      = 3;
  localparam int STAT_REM_LSB  = 16;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_STATUS,
    SEL_DATA,
    SEL_RDATA
  } reg_sel_e;

  function automatic reg_sel_e decode(input logic hit, input logic [3:0] off);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (hit) begin
      case (off)
        OFF_CTRL:   sel = SEL_CTRL;
        OFF_STATUS: sel = SEL_STATUS;
        OFF_DATA:   sel = SEL_DATA;
        OFF_RDATA:  sel = SEL_RDATA;
        default:    sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/sr_prog_ctrl_if.sv
// Wishbone-style register bus between the slave decode and the programming controller.
interface sr_prog_ctrl_if;
  logic [31:0] wb_addr;
  logic        wen;
  logic        valid;
  logic        ready;
  logic [31:0] wProgData;
  logic [31:0] rProgData;

  modport master (output wb_addr, wen, valid, wProgData, input ready, rProgData);
  modport slave  (input wb_addr, wen, valid, wProgData, output ready, rProgData);
endinterface

// File: rtl/sr_word_serializer.sv
// Shifts one word LSB-first into the chain and captures the bits coming back out.
module sr_word_serializer
  import sr_prog_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [5:0]        nbits,
  input  logic [WORD_W-1:0] data,
  input  logic              sout,
  output logic              sin,
  output logic              shift,
  output logic              last,
  output logic [WORD_W-1:0] rx_word
);

  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] rx_q;
  logic [WORD_W-1:0] rx_next;
  logic [5:0]        cnt_q;
  logic [4:0]        idx_q;

  assign shift = (cnt_q != 6'd0);
  assign last  = (cnt_q == 6'd1);
  assign sin   = shift & word_q[0];

  // sout is captured in the same cycle as the shift that moves that bit.
  always_comb begin
    rx_next = rx_q;
    if (shift) rx_next[idx_q] = sout;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q  <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      rx_word <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      word_q <= data;
      rx_q   <= '0;
      cnt_q  <= nbits;
      idx_q  <= '0;
    end else if (shift) begin
      word_q <= word_q >> 1;
      rx_q   <= rx_next;
      cnt_q  <= cnt_q - 6'd1;
      idx_q  <= idx_q + 5'd1;
      if (last) rx_word <= rx_next;
    end
  end

endmodule

// File: rtl/sr_prog_ctrl.sv
// Word-level programming controller: register decode, bus handshake, load FSM and bit budget.
module sr_prog_ctrl
  import sr_prog_pkg::*;
#(
  parameter int          CHAIN_LEN = 164,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic          clk,
  input  logic          reset,
  sr_prog_ctrl_if.slave bus,
  input  logic          sr_sout,
  output logic          sr_sin,
  output logic          sr_shift,
  output logic          sr_latch
);

  state_e            state_q, state_d;
  logic [15:0]       bits_rem_q;
  logic              done_q, err_q, ready_q, req_wr_q;
  logic [WORD_W-1:0] rdata_q, req_data_q;
  reg_sel_e          sel, req_sel_q;
  logic              data_blocked, ack, ctrl_wr, data_wr, start, abort, load;
  logic              ser_last;
  logic [5:0]        nbits;
  logic [WORD_W-1:0] rx_word, status, read_mux;

  assign sel          = decode(bus.wb_addr[31:4] == BASE_ADDR[31:4], bus.wb_addr[3:0]);
  assign data_blocked = bus.wen && (sel == SEL_DATA) &&
                        (state_q != ST_IDLE) && (state_q != ST_WAIT_WORD);
  assign ack          = bus.valid && !ready_q && !data_blocked;

  // Requests are latched at acknowledge and executed at the end of the ready cycle,
  // so the master may drop valid as soon as it sees ready.
  assign ctrl_wr = ready_q && req_wr_q && (req_sel_q == SEL_CTRL);
  assign data_wr = ready_q && req_wr_q && (req_sel_q == SEL_DATA);
  assign abort   = ctrl_wr && req_data_q[CTRL_ABORT];
  assign start   = ctrl_wr && req_data_q[CTRL_START] && !abort && (state_q == ST_IDLE);
  assign load    = data_wr && (state_q == ST_WAIT_WORD);
  assign nbits   = (bits_rem_q >= 16'(WORD_W)) ? 6'(WORD_W) : bits_rem_q[5:0];

  always_comb begin
    status                              = '0;
    status[STAT_BUSY]                   = (state_q != ST_IDLE);
    status[STAT_DONE]                   = done_q;
    status[STAT_WORD_REQ]               = (state_q == ST_WAIT_WORD);
    status[STAT_ERR]                    = err_q;
    status[STAT_REM_LSB +: 16]          = bits_rem_q;
  end

  always_comb begin
    case (sel)
      SEL_STATUS: read_mux = status;
      SEL_RDATA:  read_mux = rx_word;
      default:    read_mux = '0;
    endcase
  end

  sr_word_serializer u_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .clear   (abort),
    .nbits   (nbits),
    .data    (req_data_q),
    .sout    (sr_sout),
    .sin     (sr_sin),
    .shift   (sr_shift),
    .last    (ser_last),
    .rx_word (rx_word)
  );

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    sr_latch = (state_q == ST_LATCH);
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (start) state_d = ST_WAIT_WORD;
        ST_WAIT_WORD: if (load)  state_d = ST_SHIFT;
        ST_SHIFT:     if (sr_shift && ser_last)
                        state_d = (bits_rem_q == 16'd1) ? ST_LATCH : ST_WAIT_WORD;
        ST_LATCH:     state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      req_sel_q  <= SEL_NONE;
      req_wr_q   <= 1'b0;
      req_data_q <= '0;
      bits_rem_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ack;
      rdata_q <= (ack && !bus.wen) ? read_mux : '0;
      if (ack) begin
        req_sel_q  <= sel;
        req_wr_q   <= bus.wen;
        req_data_q <= bus.wProgData;
      end

      if (abort)         bits_rem_q <= '0;
      else if (start)    bits_rem_q <= 16'(CHAIN_LEN);
      else if (sr_shift) bits_rem_q <= bits_rem_q - 16'd1;

      if (abort || start)            done_q <= 1'b0;
      else if (state_q == ST_LATCH)  done_q <= 1'b1;

      if (start)                                 err_q <= 1'b0;
      else if (data_wr && state_q == ST_IDLE)    err_q <= 1'b1;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.rProgData = rdata_q;

endmodule

// File: tb/tb_sr_prog_ctrl.sv
// Randomized self-checking bench for sr_prog_ctrl with a behavioural chain and load model.
module tb_sr_prog_ctrl;
  import sr_prog_pkg::*;

  localparam int          L      = 164;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int          NWORDS = (L + 31) / 32;

  logic clk = 1'b0;
  logic reset;
  logic sr_sout, sr_sin, sr_shift, sr_latch;
  always #5 clk = ~clk;

  sr_prog_ctrl_if bus ();

  sr_prog_ctrl #(.CHAIN_LEN(L), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .sr_sout  (sr_sout),
    .sr_sin   (sr_sin),
    .sr_shift (sr_shift),
    .sr_latch (sr_latch)
  );

  // Physical chain: new bits enter at bit 0, sr_sout is the MSB end.
  logic [L-1:0] chain, preload_val;
  logic         preload_req;
  assign sr_sout = chain[L-1];
  always @(posedge clk) begin
    if (preload_req)   chain <= preload_val;
    else if (sr_shift) chain <= {chain[L-2:0], sr_sin};
  end

  int   cyc = 0, shift_cnt = 0, latch_cnt = 0, sin_bad = 0;
  int   last_shift_cyc = 0, latch_cyc = 0;
  logic sin_log [0:4095];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sr_shift) begin
      sin_log[shift_cnt] <= sr_sin;
      shift_cnt          <= shift_cnt + 1;
      last_shift_cyc     <= cyc;
    end
    if (sr_latch) begin
      latch_cnt <= latch_cnt + 1;
      latch_cyc <= cyc;
    end
    if (!sr_shift && sr_sin !== 1'b0) sin_bad <= sin_bad + 1;
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference model: preloaded chain image and the words written for the current load.
  logic [L-1:0] pre;
  logic [31:0]  words [NWORDS];

  function automatic logic bit_of(input int g);
    return words[g / 32][g % 32];
  endfunction

  function automatic logic [31:0] exp_rdata(input int w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 32; k++)
      if (32 * w + k < L) r[k] = pre[L - 1 - (32 * w + k)];
    return r;
  endfunction

  function automatic logic [31:0] status_word(input bit busy, input bit done, input bit wreq,
                                              input bit err, input int rem);
    logic [15:0] r16;
    r16 = rem[15:0];
    return {r16, 12'h000, err, wreq, done, busy};
  endfunction

  task automatic bus_xfer(input logic [3:0] off, input logic w, input logic [31:0] d,
                          output logic [31:0] rd, output bit acked);
    bus.wb_addr   = BASE | {28'h0, off};
    bus.wen       = w;
    bus.wProgData = d;
    bus.valid     = 1'b1;
    acked         = 1'b0;
    rd            = '0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.ready) begin
        acked = 1'b1;
        rd    = bus.rProgData;
        break;
      end
    end
    bus.valid = 1'b0;
    bus.wen   = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d, input string tag);
    logic [31:0] rd;
    bit          a;
    bus_xfer(off, 1'b1, d, rd, a);
    check({tag, "_ack"}, a, 1);
  endtask

  task automatic rd_reg(input logic [3:0] off, output logic [31:0] v);
    bit a;
    bus_xfer(off, 1'b0, 32'h0, v, a);
    if (!a) check("read_ack", a, 1);
  endtask

  task automatic wait_status(input logic [31:0] mask, output logic [31:0] st);
    bit hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      rd_reg(OFF_STATUS, st);
      if ((st & mask) != 0) begin
        hit = 1'b1;
        break;
      end
    end
    check("status_poll", hit, 1);
  endtask

  task automatic wait_shifts(input int base, input int n);
    bit hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (shift_cnt - base >= n) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check("shift_wait", hit, 1);
  endtask

  task automatic preload_random();
    for (int j = 0; j < L; j++) pre[j] = 1'($urandom_range(0, 1));
    preload_val = pre;
    preload_req = 1'b1;
    step();
    preload_req = 1'b0;
  endtask

  task automatic full_load(input bit poll, input bit a5);
    logic [31:0] st, rv;
    int          base, lbase, mism;
    preload_random();
    for (int w = 0; w < NWORDS; w++) words[w] = a5 ? 32'hA5A5_A5A5 : $urandom;
    base  = shift_cnt;
    lbase = latch_cnt;
    wr(OFF_CTRL, 32'h1, "start");
    rd_reg(OFF_STATUS, st);
    check("status_started", st, status_word(1, 0, 1, 0, L));
    for (int w = 0; w < NWORDS; w++) begin
      if (!poll && ($urandom_range(0, 3) == 0)) step();
      wr(OFF_DATA, words[w], "data");
      if (w == 0) begin
        check("shift_at_ack", sr_shift, 0);
        step();
        check("shift_after_ack", sr_shift, 1);
      end
      if (poll) begin
        wait_status(32'h6, st);
        if (w < NWORDS - 1) check("status_wreq", st, status_word(1, 0, 1, 0, L - 32 * (w + 1)));
        rd_reg(OFF_RDATA, rv);
        check("rdata_word", rv, exp_rdata(w));
      end
    end
    wait_status(32'h2, st);
    check("status_done", st, status_word(0, 1, 0, 0, 0));
    rd_reg(OFF_RDATA, rv);
    check("rdata_last", rv, exp_rdata(NWORDS - 1));
    check("shift_count", shift_cnt - base, L);
    check("latch_count", latch_cnt - lbase, 1);
    check("latch_timing", latch_cyc - last_shift_cyc, 1);
    mism = 0;
    for (int g = 0; g < L; g++) if (sin_log[base + g] !== bit_of(g)) mism++;
    check("sin_sequence", mism, 0);
    mism = 0;
    for (int j = 0; j < L; j++) if (chain[j] !== bit_of(L - 1 - j)) mism++;
    check("chain_image", mism, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] st, rv;
    int          base, sc, lc;

    reset = 1'b1;
    bus.valid = 1'b0; bus.wen = 1'b0; bus.wb_addr = '0; bus.wProgData = '0;
    preload_req = 1'b0; preload_val = '0;
    step();
    preload_req = 1'b1;
    step();
    preload_req = 1'b0;
    step();
    check("rst_ready", bus.ready, 0);
    check("rst_rdata", bus.rProgData, 0);
    check("rst_sin", sr_sin, 0);
    check("rst_shift", sr_shift, 0);
    check("rst_latch", sr_latch, 0);
    reset = 1'b0;
    step();
    rd_reg(OFF_STATUS, st); check("rst_status", st, 0);
    rd_reg(OFF_RDATA, rv);  check("rst_rdata_reg", rv, 0);
    rd_reg(OFF_CTRL, rv);   check("read_ctrl_zero", rv, 0);
    rd_reg(4'h6, rv);       check("read_unmapped_zero", rv, 0);

    // Polled load with the fixed pattern, then back-to-back loads that hit backpressure.
    full_load(1'b1, 1'b1);
    full_load(1'b0, 1'b0);
    full_load(1'b0, 1'b0);

    // Abort partway into the second word.
    preload_random();
    base = shift_cnt;
    lc   = latch_cnt;
    wr(OFF_CTRL, 32'h1, "abort_start");
    wr(OFF_DATA, $urandom, "abort_w0");
    wait_status(32'h4, st);
    wr(OFF_DATA, $urandom, "abort_w1");
    wait_shifts(base, 40);
    wr(OFF_CTRL, 32'h2, "abort");
    step();
    check("abort_shift_off", sr_shift, 0);
    sc = shift_cnt;
    repeat (20) step();
    check("abort_no_more_shift", shift_cnt - sc, 0);
    check("abort_no_latch", latch_cnt - lc, 0);
    rd_reg(OFF_STATUS, st); check("abort_status", st, 0);

    // Abort wins over start; DATA in IDLE sets err; read-only writes do nothing.
    wr(OFF_CTRL, 32'h3, "abort_and_start");
    rd_reg(OFF_STATUS, st); check("abort_prio_status", st, 0);
    wr(OFF_DATA, $urandom, "idle_data");
    sc = shift_cnt;
    repeat (10) step();
    check("idle_data_no_shift", shift_cnt - sc, 0);
    rd_reg(OFF_STATUS, st); check("idle_data_err", st, status_word(0, 0, 0, 1, 0));
    wr(OFF_STATUS, 32'hFFFF_FFFF, "ro_write");
    wr(4'hE, 32'hFFFF_FFFF, "unmapped_write");
    rd_reg(OFF_STATUS, st); check("ro_write_status", st, status_word(0, 0, 0, 1, 0));
    wr(OFF_CTRL, 32'h1, "restart");
    rd_reg(OFF_STATUS, st); check("restart_err_clear", st, status_word(1, 0, 1, 0, L));

    // A second start mid-load is ignored; then reset during the 3rd word.
    base = shift_cnt;
    wr(OFF_DATA, $urandom, "rst_w0");
    wait_status(32'h4, st);
    wr(OFF_CTRL, 32'h1, "start_ignored");
    rd_reg(OFF_STATUS, st); check("start_ignored_status", st, status_word(1, 0, 1, 0, L - 32));
    wr(OFF_DATA, $urandom, "rst_w1");
    wait_status(32'h4, st);
    wr(OFF_DATA, $urandom, "rst_w2");
    wait_shifts(base, 70);
    check("rst_mid_shift_active", sr_shift, 1);
    reset = 1'b1;
    step();
    check("rst2_shift", sr_shift, 0);
    check("rst2_sin", sr_sin, 0);
    check("rst2_latch", sr_latch, 0);
    check("rst2_ready", bus.ready, 0);
    reset = 1'b0;
    step();
    rd_reg(OFF_STATUS, st); check("rst2_status", st, 0);
    rd_reg(OFF_RDATA, rv);  check("rst2_rdata_reg", rv, 0);

    full_load(1'b1, 1'b0);

    check("sin_zero_when_idle", sin_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
